// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose: FSM state encoding, default geometry/latency, full-word byte
// enable and a byte-merge helper shared by dmem_responder and dmem_array.
// Ports: none (package).

package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_DEPTH_LOG2  = 6;
  localparam int DEF_WAIT_CYCLES = 2;

  localparam logic [3:0] BE_FULL = 4'b1111;

  // Replace only the enabled bytes of old_word with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-enabled word storage with synchronous read and async clear
//
// Purpose: 2^DEPTH_LOG2 x 32-bit storage. Writes and reads happen on the
// rising edge; reset clears every word and the read register.
// Ports:
//   clk, rst_n  clock, asynchronous active-low clear
//   idx         word index
//   we, be      write strobe and per-byte enables
//   wdata       write data
//   rd_en       capture mem[idx] into rdata on this edge
//   rdata       registered read data

module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  input  logic                  rd_en,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[idx] <= merge_bytes(mem[idx], wdata, be);
      if (rd_en) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated req/ready data-memory responder for the core
//
// Purpose: accepts one load/store at a time, holds it for WAIT_CYCLES wait
// states, then pulses ready for one cycle with rdata/err. Misaligned,
// below-base and beyond-top accesses return err=1 and never touch storage.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req, we     request valid, 1=store 0=load
//   addr        byte address
//   wdata, be   store data and byte enables (be ignored for loads)
//   ready       one-cycle response strobe
//   rdata       load data while ready=1, otherwise 0
//   err         error flag while ready=1

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  // Byte span of the array, one bit wider so 4*2^30 still fits.
  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic [31:0]   offset;
  logic          dec_err;
  logic          enter_resp;
  logic          arr_we;
  logic          arr_rd;
  logic [31:0]   arr_rdata;

  // With no wait states the request is committed on the same edge that
  // accepts it, so decode must look at the live inputs while in IDLE.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == ST_IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_be    = be;
    end
  end

  always_comb begin
    offset  = cur_addr - BASE_ADDR;
    dec_err = (cur_addr[1:0] != 2'b00) ||
              (cur_addr < BASE_ADDR) ||
              ({1'b0, offset} >= SPAN);
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state == ST_IDLE && req && WAIT_CYCLES == 0) enter_resp = 1'b1;
    if (state == ST_WAIT && cnt == '0) enter_resp = 1'b1;
    arr_we = enter_resp && cur_we && !dec_err;
    arr_rd = enter_resp && !cur_we && !dec_err;
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (offset[DEPTH_LOG2+1:2]),
    .we    (arr_we),
    .be    (cur_be),
    .wdata (cur_wdata),
    .rd_en (arr_rd),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state <= ST_RESP;
              ready <= 1'b1;
              err   <= dec_err;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
            ready <= 1'b1;
            err   <= dec_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  // Stores and errored loads present zero; the array register is only
  // meaningful for a successful load.
  assign rdata = (ready && !err && !we_q) ? arr_rdata : '0;

endmodule
